key_expansion: RTL

Iterative AES-128 key schedule that expands a 128-bit cipher key into the 11 round keys (round 0 to round 10) and buffers them for the cipher datapath. It sits directly downstream of `rcon`: it drives `rcon`'s 4-bit `rkey_sel` from its round counter and consumes the 8-bit round constant. It computes one round key per clock and exposes all stored keys through an indexed combinational read port.

---
 rtl/key_expansion.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/key_expansion.sv
// ---------------------------------------------------------------------------
// key_expansion: iterative AES-128 key schedule.
//
// Expands a 128-bit cipher key into round keys 0..10. It produces one round
// key per clock and stores every key for the cipher datapath, which reads
// them back through an indexed combinational port.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   start      in   1    expansion request, accepted only while busy=0
//   key_in     in   128  cipher key, w0 in [127:96], w3 in [31:0]
//   rd_idx     in   4    round-key index to read (0..10)
//   rd_key     out  128  stored round key rd_idx, 0 when rd_idx > 10
//   busy       out  1    expansion in progress
//   done       out  1    one-cycle pulse after round key 10 is written
//   keys_valid out  1    all 11 round keys are stored and stable
//
// Also in this file:
//   rcon      round constant lookup driven by the round counter
//   aes_sbox  combinational AES S-box (GF(2^8) inverse followed by affine map)
// ---------------------------------------------------------------------------

// Round constant: rkey_sel_i 1..10 gives rcon[1..10]; any other value gives 0.
module rcon (
  input  logic [3:0] rkey_sel_i,
  output logic [7:0] rcon_o
);

  // Round constant lookup table
  always_comb begin
    rcon_o = 8'h00;
    case (rkey_sel_i)
      4'd1:    rcon_o = 8'h01;
      4'd2:    rcon_o = 8'h02;
      4'd3:    rcon_o = 8'h04;
      4'd4:    rcon_o = 8'h08;
      4'd5:    rcon_o = 8'h10;
      4'd6:    rcon_o = 8'h20;
      4'd7:    rcon_o = 8'h40;
      4'd8:    rcon_o = 8'h80;
      4'd9:    rcon_o = 8'h1b;
      4'd10:   rcon_o = 8'h36;
      default: rcon_o = 8'h00;
    endcase
  end

endmodule

// AES S-box built arithmetically rather than as a 256-entry table.
// The multiplicative inverse is x^254 in GF(2^8), which also maps 0 to 0.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    gf_mul = acc;
  endfunction

  // Left-to-right square-and-multiply over the exponent 254 = 8'b1111_1110.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, a);
    end
    gf_inv = r;
  endfunction

  logic [7:0] inv_s;

  // Inverse followed by the AES affine transform
  always_comb begin
    inv_s  = gf_inv(data_i);
    data_o = inv_s
           ^ {inv_s[6:0], inv_s[7]}
           ^ {inv_s[5:0], inv_s[7:6]}
           ^ {inv_s[4:0], inv_s[7:5]}
           ^ {inv_s[3:0], inv_s[7:4]}
           ^ 8'h63;
  end

endmodule

module key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         busy,
  output logic         done,
  output logic         keys_valid
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  state_t       state_q;
  logic [3:0]   round_cnt_q;
  logic         busy_q;
  logic         done_q;
  logic         keys_valid_q;
  logic [127:0] key_mem_q [0:10];

  logic [127:0] prev_key_s;
  logic [31:0]  rot_word_s;
  logic [31:0]  sub_word_s;
  logic [7:0]   rcon_s;
  logic [31:0]  t_s;
  logic [31:0]  w0_s;
  logic [31:0]  w1_s;
  logic [31:0]  w2_s;
  logic [31:0]  w3_s;
  logic [127:0] round_key_d;

  rcon u_rcon (
    .rkey_sel_i (round_cnt_q),
    .rcon_o     (rcon_s)
  );

  aes_sbox u_sbox0 (.data_i(rot_word_s[31:24]), .data_o(sub_word_s[31:24]));
  aes_sbox u_sbox1 (.data_i(rot_word_s[23:16]), .data_o(sub_word_s[23:16]));
  aes_sbox u_sbox2 (.data_i(rot_word_s[15:8]),  .data_o(sub_word_s[15:8]));
  aes_sbox u_sbox3 (.data_i(rot_word_s[7:0]),   .data_o(sub_word_s[7:0]));

  // Previous round key is slot round_cnt-1; guarded so an idle counter of 0 never wraps to 15
  always_comb begin
    prev_key_s = 128'h0;
    if ((round_cnt_q != 4'd0) && (round_cnt_q <= 4'd10)) begin
      prev_key_s = key_mem_q[round_cnt_q - 4'd1];
    end else begin
      prev_key_s = 128'h0;
    end
  end

  // RotWord of p3 feeds the S-boxes; the byte rotation is (b,c,d,a)
  assign rot_word_s = {prev_key_s[23:0], prev_key_s[31:24]};

  // Round key combine: t then the chained word XORs
  always_comb begin
    t_s         = sub_word_s ^ {rcon_s, 24'h000000};
    w0_s        = prev_key_s[127:96] ^ t_s;
    w1_s        = prev_key_s[95:64]  ^ w0_s;
    w2_s        = prev_key_s[63:32]  ^ w1_s;
    w3_s        = prev_key_s[31:0]   ^ w2_s;
    round_key_d = {w0_s, w1_s, w2_s, w3_s};
  end

  // Control FSM, key storage and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      round_cnt_q  <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i < 11; i++) begin
        key_mem_q[i] <= 128'h0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            key_mem_q[0] <= key_in;
            round_cnt_q  <= 4'd1;
            busy_q       <= 1'b1;
            keys_valid_q <= 1'b0;
            state_q      <= ST_EXPAND;
          end else begin
            round_cnt_q  <= 4'd0;
          end
        end
        ST_EXPAND: begin
          key_mem_q[round_cnt_q] <= round_key_d;
          if (round_cnt_q == 4'd10) begin
            round_cnt_q  <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            keys_valid_q <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            round_cnt_q  <= round_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          round_cnt_q <= 4'd0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Indexed read port; indices beyond the last slot read as zero
  always_comb begin
    rd_key = 128'h0;
    if (rd_idx <= 4'd10) begin
      rd_key = key_mem_q[rd_idx];
    end else begin
      rd_key = 128'h0;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = keys_valid_q;

endmodule
